// File: rtl/dp_ram_arb.sv
// True dual-port RAM with valid/ready handshake, byte-lane writes, 1- or 2-stage read pipeline,
// same-address conflict arbitration with a fairness flag, and optional zero-fill after reset.
module dp_ram_arb #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_WIDTH    = 8,
   parameter int READ_LATENCY  = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               p0_req,
   input  logic                               p0_we,
   input  logic [ADDR_WIDTH-1:0]              p0_addr,
   input  logic [DATA_WIDTH-1:0]              p0_wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   p0_be,
   output logic                               p0_ready,
   output logic                               p0_rvalid,
   output logic [DATA_WIDTH-1:0]              p0_rdata,
   input  logic                               p1_req,
   input  logic                               p1_we,
   input  logic [ADDR_WIDTH-1:0]              p1_addr,
   input  logic [DATA_WIDTH-1:0]              p1_wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   p1_be,
   output logic                               p1_ready,
   output logic                               p1_rvalid,
   output logic [DATA_WIDTH-1:0]              p1_rdata,
   output logic                               init_done,
   output logic [15:0]                        conflict_cnt
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   init_addr;
   logic                    prio;
   logic                    run;
   logic                    conflict;
   logic [1:0]              acc_wr, acc_rd;
   logic [ADDR_WIDTH-1:0]   addr  [2];
   logic [DATA_WIDTH-1:0]   wdata [2];
   logic [NB-1:0]           be    [2];
   logic [1:0]              rvalid;
   logic [DATA_WIDTH-1:0]   rdata [2];
   logic [DATA_WIDTH-1:0]   mem   [DEPTH];

   assign addr[0]  = p0_addr;
   assign addr[1]  = p1_addr;
   assign wdata[0] = p0_wdata;
   assign wdata[1] = p1_wdata;
   assign be[0]    = p0_be;
   assign be[1]    = p1_be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (INIT_ON_RESET == 0 || init_addr == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_RUN;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                init_addr <= '0;
      else if (state == ST_INIT) init_addr <= init_addr + 1'b1;
   end

   assign run       = (state == ST_RUN);
   assign init_done = run;
   assign conflict  = p0_req && p1_req && (p0_addr == p1_addr) && (p0_we || p1_we);
   // On a conflict the flag picks the winner; the loser is guaranteed the next cycle.
   assign p0_ready  = run && !(conflict && prio);
   assign p1_ready  = run && !(conflict && !prio);
   assign acc_wr    = {p1_req && p1_ready && p1_we,  p0_req && p0_ready && p0_we};
   assign acc_rd    = {p1_req && p1_ready && !p1_we, p0_req && p0_ready && !p0_we};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio         <= 1'b0;
         conflict_cnt <= '0;
      end else if (run) begin
         if (p1_req && p1_ready) prio <= 1'b0;
         else if (p1_req)        prio <= 1'b1;
         if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_INIT && INIT_ON_RESET != 0) begin
         mem[init_addr] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (acc_wr[k]) begin
               for (int i = 0; i < NB; i++) begin
                  if (be[k][i]) mem[addr[k]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k][i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end
   end

   // Read data is captured at the accepting edge, so it reflects the array before that edge's writes.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
         end else begin
            v1 <= acc_rd[p];
            if (acc_rd[p]) d1 <= mem[addr[p]];
         end
      end

      if (READ_LATENCY == 2) begin : g_lat2
         logic                  v2;
         logic [DATA_WIDTH-1:0] d2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               if (v1) d2 <= d1;
            end
         end

         assign rvalid[p] = v2;
         assign rdata[p]  = d2;
      end else begin : g_lat1
         assign rvalid[p] = v1;
         assign rdata[p]  = d1;
      end
   end

   assign p0_rvalid = rvalid[0];
   assign p1_rvalid = rvalid[1];
   assign p0_rdata  = rdata[0];
   assign p1_rdata  = rdata[1];

endmodule

// File: tb/tb_dp_ram_arb.sv
// Bench for dp_ram_arb: two instances (read latency 1 and 2) share stimulus and are compared
// every cycle against a behavioural memory/arbitration model, plus a few literal expectations.
module tb_dp_ram_arb;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 16;

   bit              clk;
   logic            rst_n;
   logic            p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0]   p0_addr, p1_addr;
   logic [DW-1:0]   p0_wdata, p1_wdata;
   logic [NB-1:0]   p0_be, p1_be;
   logic            rdy0  [2];
   logic            rdy1  [2];
   logic            idone [2];
   logic [15:0]     ccnt  [2];
   logic            rv    [4];
   logic [DW-1:0]   rd    [4];

   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;

   logic [DW-1:0]   mmem [DEPTH];
   int              m_edges = 0;
   int              m_cnt = 0;
   int              m_fav = 0;
   bit              m_run = 0;
   int              qdue [4][$];
   logic [DW-1:0]   qdat [4][$];
   logic [DW-1:0]   lastd [4];
   logic            acc_seen0 = 0;
   logic            acc_seen1 = 0;

   logic            n_r0, n_w0, n_r1, n_w1;
   logic [AW-1:0]   n_a0, n_a1;
   logic [DW-1:0]   n_d0, n_d1;
   logic [NB-1:0]   n_b0, n_b1;
   int              acc_at;
   logic            pend;

   dp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(1), .INIT_ON_RESET(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ready(rdy0[0]), .p0_rvalid(rv[0]), .p0_rdata(rd[0]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ready(rdy1[0]), .p1_rvalid(rv[1]), .p1_rdata(rd[1]),
      .init_done(idone[0]), .conflict_cnt(ccnt[0])
   );

   dp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(2), .INIT_ON_RESET(1)) dut_l2 (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ready(rdy0[1]), .p0_rvalid(rv[2]), .p0_rdata(rd[2]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ready(rdy1[1]), .p1_rvalid(rv[3]), .p1_rdata(rd[3]),
      .init_done(idone[1]), .conflict_cnt(ccnt[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      m_run   = 0;
      m_edges = 0;
      m_fav   = 0;
      m_cnt   = 0;
      for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
      for (int i = 0; i < 4; i++) begin
         qdue[i].delete();
         qdat[i].delete();
         lastd[i] = '0;
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic [NB-1:0] b0,
                                input logic r1, input logic w1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d1, input logic [NB-1:0] b1);
      @(posedge clk);
      #1;
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_be = b0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_be = b1;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Compare registered outputs against the state after the last edge, then the combinational
   // readys, then advance the model across the coming edge.
   always @(negedge clk) begin : compare
      logic            conf;
      logic            exp_v;
      int              stalled;
      logic            er  [2];
      logic            acc [2];
      logic            rq  [2];
      logic            wq  [2];
      logic [AW-1:0]   ad  [2];
      logic [DW-1:0]   wd  [2];
      logic [DW-1:0]   rdv [2];
      logic [NB-1:0]   bq  [2];

      if (!rst_n) modelReset();

      for (int i = 0; i < 4; i++) begin
         exp_v = 1'b0;
         if (qdue[i].size() > 0) exp_v = (qdue[i][0] == cyc);
         if (exp_v) begin
            lastd[i] = qdat[i][0];
            void'(qdue[i].pop_front());
            void'(qdat[i].pop_front());
         end
         checkOutput($sformatf("rvalid[%0d]", i), 32'(rv[i]), 32'(exp_v));
         checkOutput($sformatf("rdata[%0d]", i), rd[i], lastd[i]);
      end
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("init_done[%0d]", k), 32'(idone[k]), 32'(m_run));
         checkOutput($sformatf("conflict_cnt[%0d]", k), 32'(ccnt[k]), 32'(m_cnt));
      end

      rq[0] = p0_req;   rq[1] = p1_req;
      wq[0] = p0_we;    wq[1] = p1_we;
      ad[0] = p0_addr;  ad[1] = p1_addr;
      wd[0] = p0_wdata; wd[1] = p1_wdata;
      bq[0] = p0_be;    bq[1] = p1_be;
      conf    = rq[0] && rq[1] && (ad[0] == ad[1]) && (wq[0] || wq[1]);
      stalled = conf ? (1 - m_fav) : -1;
      for (int p = 0; p < 2; p++) er[p] = m_run && (stalled != p);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("p0_ready[%0d]", k), 32'(rdy0[k]), 32'(er[0]));
         checkOutput($sformatf("p1_ready[%0d]", k), 32'(rdy1[k]), 32'(er[1]));
      end
      acc_seen0 = rq[0] && rdy0[0];
      acc_seen1 = rq[1] && rdy1[0];

      if (rst_n && !m_run) begin
         m_edges++;
         if (m_edges >= DEPTH) m_run = 1;
      end else if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            acc[p] = rq[p] && er[p];
            rdv[p] = mmem[ad[p]];
         end
         for (int p = 0; p < 2; p++) begin
            if (acc[p] && !wq[p]) begin
               for (int k = 0; k < 2; k++) begin
                  qdue[k*2 + p].push_back(cyc + k + 1);
                  qdat[k*2 + p].push_back(rdv[p]);
               end
            end
            if (acc[p] && wq[p]) begin
               for (int i = 0; i < NB; i++) begin
                  if (bq[p][i]) mmem[ad[p]][8*i +: 8] = wd[p][8*i +: 8];
               end
            end
         end
         if (rq[1] && !acc[1]) m_fav = 1;
         if (acc[1]) m_fav = 0;
         if (conf && m_cnt < 65535) m_cnt++;
      end
   end

   initial begin
      rst_n = 0;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      // A write presented during INIT must be ignored.
      p0_req = 1; p0_we = 1; p0_addr = 0; p0_wdata = 32'hFFFFFFFF; p0_be = 4'hF;
      repeat (15) @(posedge clk);
      #1;
      p0_req = 0;
      @(negedge clk); #1;
      checkOutput("init_done_at_15", 32'(idone[0]), 32'd0);
      @(negedge clk); #1;
      checkOutput("init_done_at_16", 32'(idone[0]), 32'd1);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("rd0_rvalid", 32'(rv[0]), 32'd1);
      checkOutput("rd0_after_init", rd[0], 32'h0);

      applyStimulus(1, 1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("rd5_lanes", rd[0], 32'h00BB00DD);

      applyStimulus(1, 1, 3, 32'h1, 4'hF, 1, 1, 3, 32'h2, 4'hF);
      @(negedge clk); #1;
      checkOutput("conf_p0_ready", 32'(rdy0[0]), 32'd1);
      checkOutput("conf_p1_stalled", 32'(rdy1[0]), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 3, 32'h2, 4'hF);
      @(negedge clk); #1;
      checkOutput("conf_p1_next", 32'(rdy1[0]), 32'd1);
      applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("conf_cnt_1", 32'(ccnt[0]), 32'd1);
      checkOutput("conf_mem3", rd[0], 32'h2);

      acc_at = -1;
      pend   = 1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1, 1, 7, 32'(c + 10), 4'hF, pend, 1, 7, 32'h77, 4'hF);
         @(negedge clk); #1;
         if (pend && rdy1[0]) begin
            acc_at = c;
            pend   = 0;
         end
      end
      applyIdle();
      @(negedge clk); #1;
      checkOutput("starve_p1_accept_cycle", 32'(acc_at), 32'd1);
      checkOutput("starve_cnt_3", 32'(ccnt[0]), 32'd3);

      applyStimulus(1, 1, 0, 32'hA0A0A0A0, 4'hF, 1, 1, 1, 32'hA1A1A1A1, 4'hF);
      applyStimulus(1, 1, 2, 32'hA2A2A2A2, 4'hF, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("lat2_rd_addr1", rd[2], 32'hA1A1A1A1);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("lat2_rd_addr2", rd[2], 32'hA2A2A2A2);
      checkOutput("rr_no_conflict", 32'(ccnt[1]), 32'd3);

      applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n  = 0;
      p0_req = 0;
      @(negedge clk); #1;
      checkOutput("rst_rdata_zero", rd[0], 32'h0);
      checkOutput("rst_ready_zero", 32'(rdy0[0]), 32'd0);
      checkOutput("rst_init_done_zero", 32'(idone[0]), 32'd0);
      @(negedge clk); #1;
      checkOutput("rst_lat2_no_rvalid", 32'(rv[2]), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      repeat (16) @(posedge clk);
      applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      applyIdle();
      @(negedge clk); #1;
      checkOutput("reinit_rvalid", 32'(rv[0]), 32'd1);
      checkOutput("reinit_rd5_zero", rd[0], 32'h0);

      for (int n = 0; n < 1500; n++) begin
         n_r0 = p0_req; n_w0 = p0_we; n_a0 = p0_addr; n_d0 = p0_wdata; n_b0 = p0_be;
         n_r1 = p1_req; n_w1 = p1_we; n_a1 = p1_addr; n_d1 = p1_wdata; n_b1 = p1_be;
         if (!(p0_req && !acc_seen0)) begin
            n_r0 = ($urandom_range(0, 3) != 0);
            n_w0 = 1'($urandom_range(0, 1));
            n_a0 = AW'($urandom_range(0, 3));
            n_d0 = $urandom;
            n_b0 = NB'($urandom);
         end
         if (!(p1_req && !acc_seen1)) begin
            n_r1 = ($urandom_range(0, 3) != 0);
            n_w1 = 1'($urandom_range(0, 1));
            n_a1 = AW'($urandom_range(0, 3));
            n_d1 = $urandom;
            n_b1 = NB'($urandom);
         end
         applyStimulus(n_r0, n_w0, n_a0, n_d0, n_b0, n_r1, n_w1, n_a1, n_d1, n_b1);
      end
      applyIdle();
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
